// File: rtl/colisao_inimigo_if.sv
// ============================================================================
// Module : colisao_inimigo_if
// Brief  : Enemy geometry, player shot and collision-result signal bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface colisao_inimigo_if;
    logic        pausa;
    logic [9:0]  xInimigo;
    logic [9:0]  yInimigo;
    logic [9:0]  largura;
    logic [9:0]  altura;
    logic        tiroAtivo;
    logic [9:0]  xTiro;
    logic [9:0]  yTiro;
    logic        vivo;
    logic        explodindo;
    logic        acerto;
    logic        tiroConsumido;
    logic [15:0] pontuacao;
    logic        invasao;

    // Producer side: movement stage / shot logic drives geometry, reads results
    modport master (
        output pausa, xInimigo, yInimigo, largura, altura, tiroAtivo, xTiro, yTiro,
        input  vivo, explodindo, acerto, tiroConsumido, pontuacao, invasao
    );

    modport slave (
        input  pausa, xInimigo, yInimigo, largura, altura, tiroAtivo, xTiro, yTiro,
        output vivo, explodindo, acerto, tiroConsumido, pontuacao, invasao
    );
endinterface

`default_nettype wire

// File: rtl/colisao_inimigo.sv
// ============================================================================
// Module : colisao_inimigo
// Brief  : Shot/enemy collision, enemy life cycle, score and invasion flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module colisao_inimigo #(
    parameter int EXPLOSAO_CICLOS = 25000000,
    parameter int PONTOS          = 10,
    parameter int LIMITE_Y        = 440,
    parameter int TIRO_L          = 4,
    parameter int TIRO_A          = 10
) (
    input  wire logic         CLOCK_50,
    input  wire logic         resetInimigo,
    colisao_inimigo_if.slave  bus
);

    localparam int          c_CW  = (EXPLOSAO_CICLOS > 1) ? $clog2(EXPLOSAO_CICLOS) : 1;
    localparam logic [c_CW-1:0] c_FIM = c_CW'(EXPLOSAO_CICLOS - 1);

    typedef enum logic [1:0] {
        S_VIVO       = 2'd0,
        S_EXPLODINDO = 2'd1,
        S_MORTO      = 2'd2
    } estado_t;

    // Stage 1: input sample registers
    logic [9:0] r_xInimigo, r_yInimigo, r_largura, r_altura, r_xTiro, r_yTiro;
    logic       r_tiroAtivo;

    // Stage 2: FSM and registered outputs
    estado_t         r_estado, w_prox_estado;
    logic [c_CW-1:0] r_cont, w_prox_cont;
    logic [15:0]     r_pontuacao, w_prox_pontuacao;
    logic            r_invasao, w_prox_invasao;
    logic            r_acerto, w_prox_acerto;
    logic            r_tiroConsumido;
    logic            r_vivo, r_explodindo;

    logic [10:0] w_xIniFim, w_xTiroFim, w_yIniFim, w_yTiroFim;
    logic        w_overlap, w_invade;
    logic [31:0] w_soma;
    logic [15:0] w_pont_sat;

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            r_xInimigo  <= '0;
            r_yInimigo  <= '0;
            r_largura   <= '0;
            r_altura    <= '0;
            r_xTiro     <= '0;
            r_yTiro     <= '0;
            r_tiroAtivo <= 1'b0;
        end else begin
            r_xInimigo  <= bus.xInimigo;
            r_yInimigo  <= bus.yInimigo;
            r_largura   <= bus.largura;
            r_altura    <= bus.altura;
            r_xTiro     <= bus.xTiro;
            r_yTiro     <= bus.yTiro;
            r_tiroAtivo <= bus.tiroAtivo;
        end
    end

    // 11-bit sums so far edges never wrap into small values
    assign w_xIniFim  = {1'b0, r_xInimigo} + {1'b0, r_largura};
    assign w_xTiroFim = {1'b0, r_xTiro} + 11'(TIRO_L);
    assign w_yIniFim  = {1'b0, r_yInimigo} + {1'b0, r_altura};
    assign w_yTiroFim = {1'b0, r_yTiro} + 11'(TIRO_A);

    assign w_overlap = ({1'b0, r_xTiro} < w_xIniFim) && ({1'b0, r_xInimigo} < w_xTiroFim) &&
                       ({1'b0, r_yTiro} < w_yIniFim) && ({1'b0, r_yInimigo} < w_yTiroFim);
    assign w_invade  = (w_yIniFim >= 11'(LIMITE_Y));

    assign w_soma     = 32'(r_pontuacao) + 32'(PONTOS);
    assign w_pont_sat = (w_soma > 32'd65535) ? 16'hFFFF : w_soma[15:0];

    always_comb begin
        w_prox_estado    = r_estado;
        w_prox_cont      = r_cont;
        w_prox_pontuacao = r_pontuacao;
        w_prox_invasao   = r_invasao;
        w_prox_acerto    = 1'b0;
        if (!bus.pausa) begin
            case (r_estado)
                S_VIVO: begin
                    // A hit on the same edge as the invasion condition takes priority
                    if (r_tiroAtivo && w_overlap) begin
                        w_prox_estado    = S_EXPLODINDO;
                        w_prox_cont      = '0;
                        w_prox_acerto    = 1'b1;
                        w_prox_pontuacao = w_pont_sat;
                    end else if (w_invade) begin
                        w_prox_invasao = 1'b1;
                    end
                end
                S_EXPLODINDO: begin
                    if (r_cont == c_FIM) begin
                        w_prox_estado = S_MORTO;
                    end else begin
                        w_prox_cont = r_cont + 1'b1;
                    end
                end
                default: begin
                    w_prox_estado = S_MORTO;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            r_estado        <= S_VIVO;
            r_cont          <= '0;
            r_pontuacao     <= '0;
            r_invasao       <= 1'b0;
            r_acerto        <= 1'b0;
            r_tiroConsumido <= 1'b0;
            r_vivo          <= 1'b1;
            r_explodindo    <= 1'b0;
        end else begin
            r_estado        <= w_prox_estado;
            r_cont          <= w_prox_cont;
            r_pontuacao     <= w_prox_pontuacao;
            r_invasao       <= w_prox_invasao;
            r_acerto        <= w_prox_acerto;
            r_tiroConsumido <= w_prox_acerto;
            r_vivo          <= (w_prox_estado == S_VIVO);
            r_explodindo    <= (w_prox_estado == S_EXPLODINDO);
        end
    end

    assign bus.vivo          = r_vivo;
    assign bus.explodindo    = r_explodindo;
    assign bus.acerto        = r_acerto;
    assign bus.tiroConsumido = r_tiroConsumido;
    assign bus.pontuacao     = r_pontuacao;
    assign bus.invasao       = r_invasao;

endmodule

`default_nettype wire

// File: tb/tb_colisao_inimigo.sv
// ============================================================================
// Module : tb_colisao_inimigo
// Brief  : Directed self-checking bench for colisao_inimigo.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_colisao_inimigo;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    colisao_inimigo_if u_if ();
    colisao_inimigo_if u_if2 ();

    // Second instance sees identical stimulus; its large PONTOS exercises saturation
    assign u_if2.pausa     = u_if.pausa;
    assign u_if2.xInimigo  = u_if.xInimigo;
    assign u_if2.yInimigo  = u_if.yInimigo;
    assign u_if2.largura   = u_if.largura;
    assign u_if2.altura    = u_if.altura;
    assign u_if2.tiroAtivo = u_if.tiroAtivo;
    assign u_if2.xTiro     = u_if.xTiro;
    assign u_if2.yTiro     = u_if.yTiro;

    colisao_inimigo #(
        .EXPLOSAO_CICLOS (4),
        .PONTOS          (10),
        .LIMITE_Y        (440),
        .TIRO_L          (4),
        .TIRO_A          (10)
    ) u_dut (
        .CLOCK_50     (clk),
        .resetInimigo (rst),
        .bus          (u_if.slave)
    );

    colisao_inimigo #(
        .EXPLOSAO_CICLOS (4),
        .PONTOS          (70000),
        .LIMITE_Y        (440),
        .TIRO_L          (4),
        .TIRO_A          (10)
    ) u_dut2 (
        .CLOCK_50     (clk),
        .resetInimigo (rst),
        .bus          (u_if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_enemy(input int x, input int y, input int l, input int a);
        u_if.xInimigo = 10'(x);
        u_if.yInimigo = 10'(y);
        u_if.largura  = 10'(l);
        u_if.altura   = 10'(a);
    endtask

    task automatic set_shot(input logic act, input int x, input int y);
        u_if.tiroAtivo = act;
        u_if.xTiro     = 10'(x);
        u_if.yTiro     = 10'(y);
    endtask

    // Called at a falling edge: asserts reset between clock edges, releases at next fall
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        u_if.pausa = 1'b0;
        set_enemy(0, 0, 0, 0);
        set_shot(1'b0, 0, 0);
        @(negedge clk);

        // 1. Asynchronous reset from an unknown state, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk1 ("rst_vivo",       u_if.vivo, 1'b1);
        chk1 ("rst_explodindo", u_if.explodindo, 1'b0);
        chk1 ("rst_acerto",     u_if.acerto, 1'b0);
        chk1 ("rst_tiroCons",   u_if.tiroConsumido, 1'b0);
        chk16("rst_pontuacao",  u_if.pontuacao, 16'd0);
        chk1 ("rst_invasao",    u_if.invasao, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 2. Basic hit, explosion length, then MORTO ignores the shot
        set_enemy(100, 50, 30, 30);
        set_shot(1'b1, 110, 70);
        tick(2);
        chk1 ("hit_acerto",     u_if.acerto, 1'b1);
        chk1 ("hit_tiroCons",   u_if.tiroConsumido, 1'b1);
        chk16("hit_pontuacao",  u_if.pontuacao, 16'd10);
        chk1 ("hit_explodindo", u_if.explodindo, 1'b1);
        chk1 ("hit_vivo",       u_if.vivo, 1'b0);
        chk16("sat_pontuacao",  u_if2.pontuacao, 16'hFFFF);
        tick(1);
        chk1 ("hit_pulse_end",  u_if.acerto, 1'b0);
        chk1 ("hit_tc_end",     u_if.tiroConsumido, 1'b0);
        tick(2);
        chk1 ("expl_last",      u_if.explodindo, 1'b1);
        tick(1);
        chk1 ("morto_expl",     u_if.explodindo, 1'b0);
        chk1 ("morto_vivo",     u_if.vivo, 1'b0);
        tick(3);
        chk1 ("morto_no_hit",   u_if.acerto, 1'b0);
        chk16("morto_pont",     u_if.pontuacao, 16'd10);

        // 3. Touching edges do not collide; one pixel of overlap does
        pulse_reset();
        set_enemy(100, 50, 30, 30);
        set_shot(1'b1, 130, 50);
        tick(3);
        chk1 ("touch_right",    u_if.acerto, 1'b0);
        chk1 ("touch_right_v",  u_if.vivo, 1'b1);
        set_shot(1'b1, 129, 50);
        tick(2);
        chk1 ("overlap_1px",    u_if.acerto, 1'b1);
        pulse_reset();
        set_enemy(100, 50, 30, 30);
        set_shot(1'b1, 96, 50);
        tick(3);
        chk1 ("touch_left",     u_if.acerto, 1'b0);
        chk1 ("touch_left_v",   u_if.vivo, 1'b1);

        // 4. Inactive shot ignored; invasion threshold and stickiness
        pulse_reset();
        set_enemy(100, 50, 30, 30);
        set_shot(1'b0, 110, 70);
        tick(3);
        chk1 ("inactive_acerto", u_if.acerto, 1'b0);
        chk1 ("inactive_vivo",   u_if.vivo, 1'b1);
        set_enemy(100, 409, 30, 30);
        tick(3);
        chk1 ("inv_439",        u_if.invasao, 1'b0);
        set_enemy(100, 410, 30, 30);
        tick(2);
        chk1 ("inv_440",        u_if.invasao, 1'b1);
        set_enemy(100, 0, 30, 30);
        tick(3);
        chk1 ("inv_sticky",     u_if.invasao, 1'b1);
        chk1 ("inv_vivo",       u_if.vivo, 1'b1);

        // 5. Pause freezes the FSM and suppresses pulses
        pulse_reset();
        u_if.pausa = 1'b1;
        set_enemy(100, 50, 30, 30);
        set_shot(1'b1, 110, 70);
        tick(4);
        chk1 ("pause_acerto",   u_if.acerto, 1'b0);
        chk1 ("pause_vivo",     u_if.vivo, 1'b1);
        chk16("pause_pont",     u_if.pontuacao, 16'd0);
        u_if.pausa = 1'b0;
        tick(1);
        chk1 ("unpause_acerto", u_if.acerto, 1'b1);
        chk16("unpause_pont",   u_if.pontuacao, 16'd10);
        tick(1);
        u_if.pausa = 1'b1;
        tick(10);
        chk1 ("pause_expl",     u_if.explodindo, 1'b1);
        chk1 ("pause_expl_ac",  u_if.acerto, 1'b0);
        u_if.pausa = 1'b0;
        tick(2);
        chk1 ("expl_4th",       u_if.explodindo, 1'b1);
        tick(1);
        chk1 ("expl_done",      u_if.explodindo, 1'b0);
        chk1 ("expl_done_v",    u_if.vivo, 1'b0);

        // 6. Reset during EXPLODINDO
        pulse_reset();
        set_enemy(100, 50, 30, 30);
        set_shot(1'b1, 110, 70);
        tick(3);
        chk1 ("pre_rst_expl",   u_if.explodindo, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1 ("midrst_vivo",    u_if.vivo, 1'b1);
        chk1 ("midrst_expl",    u_if.explodindo, 1'b0);
        chk16("midrst_pont",    u_if.pontuacao, 16'd0);
        chk16("midrst_cont",    16'(u_dut.r_cont), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hit and invasion on the same edge: hit wins
        set_enemy(100, 420, 30, 30);
        set_shot(1'b1, 110, 430);
        tick(2);
        chk1 ("both_acerto",    u_if.acerto, 1'b1);
        chk1 ("both_invasao",   u_if.invasao, 1'b0);
        tick(3);
        chk1 ("both_inv_later", u_if.invasao, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
